// File: rtl/route_sched_pkg.sv
// Shared types and constants for the route scheduler: FSM states, command
// field layout, the parked source code and error cause encodings.
package route_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int CMD_W    = 48;
  localparam int CTRL_W   = 18;

  localparam int SRC_LSB  = 0;
  localparam int SRC_W    = 3;
  localparam int DST_LSB  = 3;
  localparam int DST_W    = 3;
  localparam int SCTL_LSB = 6;
  localparam int SCTL_W   = 3;
  localparam int SREG_LSB = 9;
  localparam int SREG_W   = 9;
  localparam int INB_LSB  = 18;
  localparam int INB_W    = 14;
  localparam int OUTB_LSB = 32;
  localparam int OUTB_W   = 16;

  localparam logic [SRC_W-1:0] SRC_PARK = 3'b111;
  localparam logic [SRC_W-1:0] SRC_MAX  = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SRC     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/route_sched.sv
// Sequences one route command at a time over the inter-switch: loads the
// switch control word, counts in/out beats, then parks the source and drains.
module route_sched
  import route_sched_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CMD_W-1:0]    cmd_tdata,
  input  logic                cmd_tvalid,
  output logic                cmd_tready,
  output logic [CTRL_W-1:0]   ctrl,
  input  logic [4:0]          in_tvalid,
  input  logic [4:0]          in_tready,
  input  logic [7:0]          out_tvalid,
  input  logic [7:0]          out_tready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_cause
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [INB_W-1:0]    in_last_q;
  logic [OUTB_W-1:0]   out_last_q;
  logic [CW-1:0]       in_cnt_q, out_cnt_q;
  logic                out_hit_q;
  logic [TW-1:0]       idle_cnt_q;
  logic                done_q, err_q;
  logic [1:0]          err_cause_q;

  logic [SRC_W-1:0]    cmd_src;
  logic [7:0]          in_hs, out_hs;
  logic                in_fire, out_fire, in_last_fire, out_last_fire;
  logic                acc_ok, acc_bad, in_step, out_step, out_hit_set;
  logic                park, fin_done, fin_to;

  assign cmd_src = cmd_tdata[SRC_LSB +: SRC_W];

  // Only the handshake bits selected by the active src/dst count; src codes
  // 5..7 index the zero padding, so a parked source never fires.
  assign in_hs   = {3'b000, in_tvalid & in_tready};
  assign out_hs  = out_tvalid & out_tready;
  assign in_fire  = in_hs[ctrl_q[SRC_LSB +: SRC_W]];
  assign out_fire = out_hs[ctrl_q[DST_LSB +: DST_W]];

  assign in_last_fire  = in_fire && (in_cnt_q == CW'(in_last_q));
  assign out_last_fire = out_fire && !out_hit_q && (out_cnt_q == CW'(out_last_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    acc_ok      = 1'b0;
    acc_bad     = 1'b0;
    in_step     = 1'b0;
    out_step    = 1'b0;
    out_hit_set = 1'b0;
    park        = 1'b0;
    fin_done    = 1'b0;
    fin_to      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_tvalid) begin
          if (cmd_src <= SRC_MAX) begin
            acc_ok  = 1'b1;
            state_d = ST_RUN;
          end else begin
            acc_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        in_step  = in_fire && !in_last_fire;
        out_step = out_fire && !out_hit_q && !out_last_fire;
        if (in_last_fire) begin
          park = 1'b1;
          if (out_hit_q || out_last_fire) begin
            state_d  = ST_IDLE;
            fin_done = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
          end
        end else if (out_last_fire) begin
          out_hit_set = 1'b1;
        end
      end
      ST_DRAIN: begin
        out_step = out_fire && !out_last_fire;
        if (out_last_fire) begin
          state_d  = ST_IDLE;
          fin_done = 1'b1;
        end else if (!out_fire && idle_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          fin_to   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= {{(CTRL_W-SRC_W){1'b0}}, SRC_PARK};
      in_last_q   <= '0;
      out_last_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_hit_q   <= 1'b0;
      idle_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= ERR_NONE;
    end else begin
      done_q <= fin_done;
      err_q  <= acc_bad | fin_to;
      if (acc_bad) err_cause_q <= ERR_SRC;
      if (fin_to)  err_cause_q <= ERR_TIMEOUT;

      if (acc_ok) begin
        ctrl_q     <= {cmd_tdata[SREG_LSB +: SREG_W], cmd_tdata[SCTL_LSB +: SCTL_W],
                       cmd_tdata[DST_LSB +: DST_W], cmd_src};
        in_last_q  <= cmd_tdata[INB_LSB +: INB_W];
        out_last_q <= cmd_tdata[OUTB_LSB +: OUTB_W];
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        out_hit_q  <= 1'b0;
      end else begin
        if (park || fin_to) ctrl_q[SRC_LSB +: SRC_W] <= SRC_PARK;
        if (in_step)        in_cnt_q  <= in_cnt_q + CW'(1);
        if (out_step)       out_cnt_q <= out_cnt_q + CW'(1);
        if (out_hit_set)    out_hit_q <= 1'b1;
      end

      // Idle counter measures consecutive beat-less DRAIN cycles only.
      if (state_q == ST_DRAIN && !out_fire) idle_cnt_q <= idle_cnt_q + TW'(1);
      else                                  idle_cnt_q <= '0;
    end
  end

  assign ctrl       = ctrl_q;
  assign cmd_tready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_cause  = err_cause_q;

endmodule

// File: tb/tb_route_sched.sv
// Directed bench for route_sched: normal transfers, rejected source, drain
// timeout, same-cycle completion and mid-command reset.
module tb_route_sched;
  import route_sched_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [CMD_W-1:0]  cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [CTRL_W-1:0] ctrl;
  logic [4:0]        in_tvalid, in_tready;
  logic [7:0]        out_tvalid, out_tready;
  logic              busy, done, err;
  logic [1:0]        err_cause;

  int vec_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  route_sched #(.TIMEOUT(8), .CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .ctrl       (ctrl),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_cause  (err_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk_cmd(input logic [2:0] src, input logic [2:0] dst,
                                         input logic [2:0] sctl, input logic [8:0] sreg,
                                         input logic [13:0] inm1, input logic [15:0] outm1);
    return {outm1, inm1, sreg, sctl, dst, src};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_io;
    in_tvalid  = '0;
    in_tready  = '0;
    out_tvalid = '0;
    out_tready = '0;
  endtask

  task automatic send(input logic [47:0] c);
    cmd_tdata  = c;
    cmd_tvalid = 1'b1;
    tick();
    cmd_tvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_tdata = '0;
    cmd_tvalid = 1'b0;
    clr_io();
    tick();
    tick();
    chk("rst_ctrl",  32'(ctrl), 32'h00007);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_cause", 32'(err_cause), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy",   32'(cmd_tready), 32'd1);

    // src=4 dst=7, three beats each, input first then output
    send(mk_cmd(3'd4, 3'd7, 3'd0, 9'd0, 14'd2, 16'd2));
    chk("t1_ctrl", 32'(ctrl), 32'h0003C);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdy",  32'(cmd_tready), 32'd0);
    in_tvalid = 5'b10000; in_tready = 5'b10000;
    tick(); tick();
    chk("t1_ctrl_run", 32'(ctrl), 32'h0003C);
    tick();
    chk("t1_park", 32'(ctrl), 32'h0003F);
    chk("t1_drain_busy", 32'(busy), 32'd1);
    clr_io();
    out_tvalid = 8'h80; out_tready = 8'h80;
    tick(); tick();
    chk("t1_no_done", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    clr_io();
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_rdy_back", 32'(cmd_tready), 32'd1);

    // src=2 dst=4, one in-beat, twelve out-beats; foreign bits ignored
    send(mk_cmd(3'd2, 3'd4, 3'd0, 9'd0, 14'd0, 16'd11));
    chk("t2_ctrl", 32'(ctrl), 32'h00022);
    in_tvalid = 5'b11011; in_tready = 5'b11111;
    tick();
    chk("t2_ignore_in", 32'(ctrl), 32'h00022);
    in_tvalid = 5'b00100;
    tick();
    chk("t2_park", 32'(ctrl), 32'h00027);
    clr_io();
    out_tvalid = 8'hEF; out_tready = 8'hFF;
    tick();
    out_tvalid = 8'h10; out_tready = 8'h10;
    repeat (11) tick();
    chk("t2_no_done", 32'(done), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_done", 32'(done), 32'd1);
    clr_io();
    tick();

    // illegal src=6 is consumed and rejected
    send(mk_cmd(3'd6, 3'd1, 3'd3, 9'h055, 14'd0, 16'd0));
    chk("t3_err",   32'(err), 32'd1);
    chk("t3_cause", 32'(err_cause), 32'h1);
    chk("t3_busy",  32'(busy), 32'd0);
    chk("t3_ctrl",  32'(ctrl), 32'h00027);
    chk("t3_rdy",   32'(cmd_tready), 32'd1);
    tick();
    chk("t3_err_pulse", 32'(err), 32'd0);

    // drain timeout with TIMEOUT=8
    send(mk_cmd(3'd1, 3'd3, 3'd0, 9'd0, 14'd1, 16'd5));
    chk("t4_ctrl", 32'(ctrl), 32'h00019);
    in_tvalid = 5'b00010; in_tready = 5'b00010;
    tick(); tick();
    clr_io();
    chk("t4_park", 32'(ctrl), 32'h0001F);
    out_tvalid = 8'h08;
    repeat (7) tick();
    chk("t4_no_err", 32'(err), 32'd0);
    chk("t4_busy",   32'(busy), 32'd1);
    tick();
    chk("t4_err",   32'(err), 32'd1);
    chk("t4_cause", 32'(err_cause), 32'h2);
    chk("t4_idle",  32'(busy), 32'd0);
    clr_io();
    tick();
    chk("t4_err_pulse", 32'(err), 32'd0);

    // single beat each, same cycle: RUN straight to IDLE
    send(mk_cmd(3'd3, 3'd5, 3'd0, 9'd0, 14'd0, 16'd0));
    chk("t5_ctrl", 32'(ctrl), 32'h0002B);
    in_tvalid = 5'b01000; in_tready = 5'b01000;
    out_tvalid = 8'h20; out_tready = 8'h20;
    tick();
    chk("t5_done",  32'(done), 32'd1);
    chk("t5_idle",  32'(busy), 32'd0);
    chk("t5_ctrl_park", 32'(ctrl), 32'h0002F);
    chk("t5_cause_hold", 32'(err_cause), 32'h2);
    clr_io();
    tick();
    chk("t5_done_pulse", 32'(done), 32'd0);
    chk("t5_still_idle", 32'(busy), 32'd0);

    // reset mid-RUN abandons the command
    send(mk_cmd(3'd0, 3'd2, 3'd5, 9'h1A5, 14'd3, 16'd3));
    chk("t6_ctrl", 32'(ctrl), 32'h34B50);
    in_tvalid = 5'b00001; in_tready = 5'b00001;
    tick();
    clr_io();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl",  32'(ctrl), 32'h00007);
    chk("t6_rst_busy",  32'(busy), 32'd0);
    chk("t6_rst_cause", 32'(err_cause), 32'd0);
    tick();
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_err",  32'(err), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_done", 32'(done), 32'd0);
    chk("t6_post_err",  32'(err), 32'd0);
    chk("t6_post_rdy",  32'(cmd_tready), 32'd1);
    send(mk_cmd(3'd4, 3'd0, 3'd0, 9'd0, 14'd0, 16'd0));
    chk("t6_new_ctrl", 32'(ctrl), 32'h00004);
    in_tvalid = 5'b10000; in_tready = 5'b10000;
    out_tvalid = 8'h01; out_tready = 8'h01;
    tick();
    chk("t6_new_done", 32'(done), 32'd1);
    clr_io();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/route_sched.md
ROUTE_SCHED -- requirements
Module: route_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max consecutive DRAIN cycles without an output beat before abort.
REQ-002 SHALL have parameter CW, default 16: counter width; in-beat field is 14 bits and out-beat field is 16 bits regardless of CW.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_tdata  input  48  route command: [2:0] src, [5:3] dst, [8:6] shift_ctrl, [17:9] shift_reg, [31:18] in_beats-1, [47:32] out_beats-1.
REQ-006 cmd_tvalid / cmd_tready  input / output  1 / 1  command AXI-Stream handshake.
REQ-007 ctrl  output  18  switch control word {shift_reg, shift_ctrl, dst, src}, registered.
REQ-008 in_tvalid, in_tready  input  5 / 5  observed switch input handshakes; bit k corresponds to src code k (bit4 = port a ... bit0 = port e).
REQ-009 out_tvalid, out_tready  input  8 / 8  observed switch output handshakes; bit k corresponds to dst code k (bit7 = a ... bit0 = h).
REQ-010 busy  output  1  high in RUN or DRAIN.
REQ-011 done  output  1  one-cycle pulse on normal command completion.
REQ-012 err  output  1  one-cycle pulse on aborted or rejected command.
REQ-013 err_cause  output  2  registered cause of the last err: 01 illegal src, 10 timeout; holds until the next err.

Function
REQ-014 States SHALL be IDLE, RUN, DRAIN.
REQ-015 cmd_tready SHALL be 1 only in IDLE.
REQ-016 In IDLE, ctrl src SHALL be 3'b111 (SRC_PARK, no input enabled); dst and shift fields hold their last values.
REQ-017 Command accepted with src in 0..4: ctrl SHALL load all command fields on the next edge, the counters SHALL clear, and the state SHALL go to RUN; ctrl SHALL then be stable until the command ends.
REQ-018 Command accepted with src in 5..7: it is consumed, state SHALL stay IDLE, err SHALL pulse next cycle, err_cause SHALL become 01.
REQ-019 in_fire = in_tvalid[src] & in_tready[src]; out_fire = out_tvalid[dst] & out_tready[dst]; only the selected bits count.
REQ-020 in_cnt SHALL increment on in_fire in RUN; out_cnt SHALL increment on out_fire in RUN and DRAIN.
REQ-021 An in_fire with in_cnt == in_beats-1 SHALL move the state to DRAIN and set ctrl src to SRC_PARK on the same edge; no further input beats SHALL be admitted.
REQ-022 An out_fire with out_cnt == out_beats-1, once the input has completed or is completing in the same cycle, SHALL return the state to IDLE and pulse done next cycle.
REQ-023 Last in-beat and last out-beat in the same cycle SHALL go RUN -> IDLE directly, with one done pulse.
REQ-024 If the out-beat target is reached while still in RUN, further out_fire SHALL NOT count, and the command SHALL complete on the last in-beat.
REQ-025 In DRAIN, the idle counter SHALL reset on every out_fire; reaching TIMEOUT SHALL go to IDLE, pulse err, and set err_cause 10.
REQ-026 in_beats-1 = 0 and out_beats-1 = 0 SHALL mean exactly one beat each; counters SHALL NOT wrap within a command.
REQ-027 A new command SHALL be accepted at the earliest in the cycle after returning to IDLE, giving a one-cycle bubble minimum.

Reset
REQ-028 rst asserted at any time SHALL force, asynchronously: state IDLE, ctrl 18'h00007, counters 0, busy 0, done 0, err 0, err_cause 00, cmd_tready 1 after release.
REQ-029 A reset mid-command SHALL abandon the command with no done or err pulse.

Structure
REQ-030 Package route_sched_pkg SHALL hold the state enum, the cmd field offsets and widths, SRC_PARK = 3'b111, and the err_cause codes.
REQ-031 No sub-module; the two beat counters and the idle counter SHALL be inline; ctrl SHALL drive inter_switch ctrl directly.

Verification
REQ-032 Bench SHALL cover: cmd src=4, dst=7, in-1=2, out-1=2, one beat per cycle -> ctrl=18'h0003C after accept, DRAIN after 3rd in_fire with src=7, done 1 cycle after 3rd out_fire.
REQ-033 Bench SHALL cover: cmd src=2, dst=4, in-1=0, out-1=11 (1536->128) -> src parked after 1 in-beat, done after 12th out_fire on bit4, in_fire on other bits ignored.
REQ-034 Bench SHALL cover: cmd src=6 -> cmd consumed in 1 cycle, err pulse, err_cause=01, busy stays 0, ctrl unchanged.
REQ-035 Bench SHALL cover: TIMEOUT=8, out_tready held 0 in DRAIN -> err pulse 8 cycles after DRAIN entry, err_cause=10, state IDLE.
REQ-036 Bench SHALL cover: in-1=0, out-1=0, in_fire and out_fire same cycle -> RUN->IDLE, single done, no DRAIN cycle.
REQ-037 Bench SHALL cover: rst asserted mid-RUN -> ctrl=18'h00007 immediately, no done or err pulse, next command runs normally.
